// File: rtl/stack_sequencer_pkg.sv
// Shared types and stack item encoding for the stack transfer sequencer.
// Mask bit i selects stack item i; the SP item gets special push/pop handling.
package stack_sequencer_pkg;

    localparam int SSQ_MASK_W = 16;
    localparam int SSQ_DATA_W = 16;

    // Stack item bit positions in the decoder's push/pop masks
    localparam int STACK_AW  = 0;
    localparam int STACK_SP  = 4;
    localparam int STACK_PC  = 13;
    localparam int STACK_IMM = 15;

    typedef enum logic [2:0] {
        SSQ_IDLE,
        SSQ_POP,
        SSQ_PUSH_DEC,
        SSQ_PUSH,
        SSQ_FIN
    } stack_seq_state_e;

endpackage

// File: rtl/stack_sequencer_encoder.sv
// Combinational priority encoder: lowest and highest set bit of a mask plus an any-set flag.
// Zero latency; no handshake. Both indices read 0 for an empty mask.
module stack_mask_encoder #(
    parameter int   MASK_W = 16,
    localparam int  IDX_W  = $clog2(MASK_W)
) (
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  lo_idx,
    output logic [IDX_W-1:0]  hi_idx,
    output logic              any
);

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) hi_idx = IDX_W'(i);
        end
    end

    assign any = |mask;

endmodule

// File: rtl/stack_sequencer.sv
// Stack transfer sequencer: one command -> pops (high bit first) then pushes (low bit first), one BIU request per item.
// Latency: pop 1 cycle + BIU wait, push 2 cycles + BIU wait; mem_req holds until mem_ack, start ignored while busy.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int   MASK_W = SSQ_MASK_W,
    parameter int   SP_BIT = STACK_SP,
    localparam int  IDX_W  = $clog2(MASK_W)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [MASK_W-1:0]     push_mask,
    input  logic [MASK_W-1:0]     pop_mask,
    input  logic [SSQ_DATA_W-1:0] sp_in,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      item_sel,
    input  logic [SSQ_DATA_W-1:0] item_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [SSQ_DATA_W-1:0] mem_addr,
    output logic [SSQ_DATA_W-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [SSQ_DATA_W-1:0] mem_rdata,
    output logic                  reg_we,
    output logic [SSQ_DATA_W-1:0] reg_wdata,
    output logic                  sp_we,
    output logic [SSQ_DATA_W-1:0] sp_out
);

    stack_seq_state_e        state_q, state_d;
    logic [MASK_W-1:0]       pop_q, pop_d;
    logic [MASK_W-1:0]       push_q, push_d;
    logic [SSQ_DATA_W-1:0]   sp_q, sp_d;
    logic [SSQ_DATA_W-1:0]   sp_start_q, sp_start_d;
    logic [SSQ_DATA_W-1:0]   wdata_q, wdata_d;

    logic [MASK_W-1:0]       active_mask;
    logic [IDX_W-1:0]        lo_idx, hi_idx;
    logic                    mask_any;
    logic [MASK_W-1:0]       one_hot_base;
    logic [MASK_W-1:0]       pop_rem, push_rem;

    assign active_mask  = (state_q == SSQ_POP) ? pop_q : push_q;
    assign one_hot_base = {{(MASK_W-1){1'b0}}, 1'b1};
    assign pop_rem      = pop_q  & ~(one_hot_base << hi_idx);
    assign push_rem     = push_q & ~(one_hot_base << lo_idx);

    stack_mask_encoder #(
        .MASK_W (MASK_W)
    ) u_encoder (
        .mask   (active_mask),
        .lo_idx (lo_idx),
        .hi_idx (hi_idx),
        .any    (mask_any)
    );

    always_comb begin
        state_d    = state_q;
        pop_d      = pop_q;
        push_d     = push_q;
        sp_d       = sp_q;
        sp_start_d = sp_start_q;
        wdata_d    = wdata_q;
        busy       = 1'b0;
        done       = 1'b0;
        item_sel   = '0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        reg_we     = 1'b0;
        reg_wdata  = '0;
        sp_we      = 1'b0;
        sp_out     = '0;

        case (state_q)
            SSQ_IDLE: begin
                if (start) begin
                    pop_d      = pop_mask;
                    push_d     = push_mask;
                    sp_d       = sp_in;
                    sp_start_d = sp_in;
                    if (|pop_mask)       state_d = SSQ_POP;
                    else if (|push_mask) state_d = SSQ_PUSH_DEC;
                    else                 state_d = SSQ_FIN;
                end
            end

            SSQ_POP: begin
                busy     = 1'b1;
                item_sel = hi_idx;
                mem_req  = mask_any;
                mem_addr = sp_q;
                if (mem_req && mem_ack) begin
                    sp_d   = sp_q + 16'd2;
                    sp_we  = 1'b1;
                    sp_out = sp_q + 16'd2;
                    // Popped SP value is read off the bus but never lands in the regfile
                    if (hi_idx != IDX_W'(SP_BIT)) begin
                        reg_we    = 1'b1;
                        reg_wdata = mem_rdata;
                    end
                    pop_d = pop_rem;
                    if (|pop_rem)     state_d = SSQ_POP;
                    else if (|push_q) state_d = SSQ_PUSH_DEC;
                    else              state_d = SSQ_FIN;
                end
            end

            SSQ_PUSH_DEC: begin
                busy     = 1'b1;
                item_sel = lo_idx;
                sp_d     = sp_q - 16'd2;
                wdata_d  = (lo_idx == IDX_W'(SP_BIT)) ? sp_start_q : item_rdata;
                state_d  = SSQ_PUSH;
            end

            SSQ_PUSH: begin
                busy      = 1'b1;
                item_sel  = lo_idx;
                mem_req   = mask_any;
                mem_wr    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = wdata_q;
                if (mem_req && mem_ack) begin
                    sp_we  = 1'b1;
                    sp_out = sp_q;
                    push_d = push_rem;
                    state_d = (|push_rem) ? SSQ_PUSH_DEC : SSQ_FIN;
                end
            end

            SSQ_FIN: begin
                done    = 1'b1;
                state_d = SSQ_IDLE;
            end

            default: state_d = SSQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SSQ_IDLE;
            pop_q      <= '0;
            push_q     <= '0;
            sp_q       <= '0;
            sp_start_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            sp_q       <= sp_d;
            sp_start_q <= sp_start_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: directed commands queue expected bus/regfile/SP events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0;
    logic        busy, done, mem_req, mem_wr, reg_we, sp_we;
    logic [3:0]  item_sel;
    logic [15:0] item_rdata, mem_addr, mem_wdata, reg_wdata, sp_out;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    logic [15:0] rd_tbl [16];
    assign item_rdata = rd_tbl[item_sel];

    stack_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .push_mask  (push_mask),
        .pop_mask   (pop_mask),
        .sp_in      (sp_in),
        .busy       (busy),
        .done       (done),
        .item_sel   (item_sel),
        .item_rdata (item_rdata),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .sp_we      (sp_we),
        .sp_out     (sp_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_t;

    mem_t        exp_mem [$];
    logic [19:0] exp_reg [$];
    logic [15:0] exp_sp  [$];
    int          done_seen = 0;
    int          wait_n = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event %h", name, act);
    endtask

    // BIU model: acks after wait_n idle cycles of mem_req, pop data = addr ^ 5A5A
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (cnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 16'h5A5A;
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        mem_t got;
        if (mem_req && mem_ack) begin
            got = '{mem_wr, item_sel, mem_addr, (mem_wr ? mem_wdata : 16'h0)};
            if (exp_mem.size() == 0) unexpected("mem_xfer", 64'(got));
            else check("mem_xfer", 64'(got), 64'(exp_mem.pop_front()));
        end
        if (reg_we) begin
            if (exp_reg.size() == 0) unexpected("reg_write", {item_sel, reg_wdata});
            else check("reg_write", {item_sel, reg_wdata}, exp_reg.pop_front());
        end
        if (sp_we) begin
            if (exp_sp.size() == 0) unexpected("sp_write", sp_out);
            else check("sp_write", sp_out, exp_sp.pop_front());
        end
        if (done) begin
            done_seen++;
            check("done_busy_low", busy, 0);
        end
    end

    task automatic issue(input logic [15:0] pm, input logic [15:0] um, input logic [15:0] sp);
        @(negedge clk);
        push_mask = pm;
        pop_mask  = um;
        sp_in     = sp;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        push_mask = '0;
        pop_mask  = '0;
    endtask

    task automatic wait_done(input string name, input int d0, input int limit);
        int n = 0;
        while (done_seen == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, done_seen, d0 + 1);
    endtask

    task automatic exp_write(input logic [3:0] sel, input logic [15:0] addr, input logic [15:0] data);
        exp_mem.push_back('{1'b1, sel, addr, data});
        exp_sp.push_back(addr);
    endtask

    task automatic exp_read(input logic [3:0] sel, input logic [15:0] addr, input logic to_reg);
        exp_mem.push_back('{1'b0, sel, addr, 16'h0});
        if (to_reg) exp_reg.push_back({sel, addr ^ 16'h5A5A});
        exp_sp.push_back(addr + 16'd2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) rd_tbl[i] = 16'hA000 + 16'(i);
        rd_tbl[13] = 16'h1234;

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_item_sel", item_sel, 0);
        check("rst_strobes", {reg_we, sp_we, mem_wr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: reset while a push request is outstanding
        wait_n = 50;
        d0 = done_seen;
        issue(16'h0001, 16'h0000, 16'h0100);
        for (int n = 0; n < 10 && !(mem_req && mem_wr); n++) @(negedge clk);
        check("abort_req_seen", {mem_req, mem_wr, busy}, 3'b111);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_sp_we", sp_we, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_seen, d0);

        // 2: single PC push, two BIU wait cycles
        wait_n = 2;
        exp_write(4'd13, 16'h00FE, 16'h1234);
        d0 = done_seen;
        issue(16'h2000, 16'h0000, 16'h0100);
        check("pc_push_busy", busy, 1);
        wait_done("pc_push_done", d0, 50);

        // 3: push items 0..7; item 4 (SP) carries the SP captured at start.
        // A second start mid-command must be ignored.
        wait_n = 1;
        for (int i = 0; i < 8; i++)
            exp_write(4'(i), 16'h01FE - 16'(2 * i), (i == 4) ? 16'h0200 : 16'hA000 + 16'(i));
        d0 = done_seen;
        issue(16'h00FF, 16'h0000, 16'h0200);
        repeat (3) @(negedge clk);
        pop_mask  = 16'hFFFF;
        push_mask = 16'hFFFF;
        sp_in     = 16'h4444;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        pop_mask  = '0;
        push_mask = '0;
        check("start_while_busy", busy, 1);
        wait_done("push8_done", d0, 200);

        // 4: pop items 7..0; item 4 is read but not written to the regfile
        wait_n = 0;
        for (int k = 0; k < 8; k++)
            exp_read(4'(7 - k), 16'h01F0 + 16'(2 * k), (k != 3));
        d0 = done_seen;
        issue(16'h0000, 16'h00FF, 16'h01F0);
        wait_done("pop8_done", d0, 200);

        // 5: pop then push across the 16-bit SP wrap
        wait_n = 1;
        exp_read(4'd13, 16'hFFFE, 1'b1);
        exp_write(4'd9, 16'hFFFE, 16'hA009);
        d0 = done_seen;
        issue(16'h0200, 16'h2000, 16'hFFFE);
        wait_done("wrap_done", d0, 50);

        // 6: empty command, then a stray ack while idle
        d0 = done_seen;
        issue(16'h0000, 16'h0000, 16'h1111);
        check("empty_done_lat", {done, mem_req}, 2'b10);
        @(negedge clk);
        check("empty_done_once", done, 0);
        repeat (2) @(negedge clk);
        check("empty_done_count", done_seen, d0 + 1);
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_ack_idle", {busy, mem_req, done}, 3'b000);

        check("mem_q_drained", exp_mem.size(), 0);
        check("reg_q_drained", exp_reg.size(), 0);
        check("sp_q_drained", exp_sp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
